// File: rtl/alu_mem_sequencer_if.sv
// alu_mem_sequencer_if: command/memory/status bundle; master = sequencer (drives cmd_ready, mem_*, done/err/result/flags), slave = host+memory
interface alu_mem_sequencer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 4);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              zero;
  modport master (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata,
    output cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, result, carry, zero
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata,
    input  cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, result, carry, zero
  );
endinterface

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: fetch two operands, run ALU, write back; ports clk, rst, bus (alu_mem_sequencer_if.master)
module alu_mem_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  alu_mem_sequencer_if.master bus
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4, OP_MAX = 3'd5;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, WRITE, DONE_ERR} state_t;
  state_t            r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_src_b, r_dst, r_addr;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_result;
  logic              r_carry, r_zero;
  logic [DATA_W:0]   w_alu;
  logic [DATA_W-1:0] w_logic;
  always_comb begin
    w_logic = r_op == OP_AND ? r_op_a & r_op_b :
              r_op == OP_OR  ? r_op_a | r_op_b :
              r_op == OP_XOR ? r_op_a ^ r_op_b : r_op_a;
    w_alu   = r_op == OP_ADD ? {1'b0, r_op_a} + {1'b0, r_op_b} :
              r_op == OP_SUB ? {1'b0, r_op_a} - {1'b0, r_op_b} : {1'b0, w_logic};
  end
  assign bus.cmd_ready = r_state == IDLE;
  assign bus.mem_rd_en = r_state == RD_A || r_state == RD_B;
  assign bus.mem_wr_en = r_state == WRITE;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_state == WRITE ? w_alu[DATA_W-1:0] : '0;
  assign bus.done      = r_state == WRITE || r_state == DONE_ERR;
  assign bus.err       = r_state == DONE_ERR;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  // r_addr is loaded one state ahead so the address is valid for the whole access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_addr   <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_op    <= bus.cmd_op;
          r_src_b <= bus.cmd_src_b;
          r_dst   <= bus.cmd_dst;
          if (bus.cmd_op > OP_MAX) r_state <= DONE_ERR;
          else begin
            r_addr  <= bus.cmd_src_a;
            r_state <= RD_A;
          end
        end
        RD_A: begin
          r_addr  <= r_src_b;
          r_state <= RD_B;
        end
        RD_B: begin
          r_op_a  <= bus.mem_rdata;
          r_state <= CAP_B;
        end
        CAP_B: begin
          r_op_b  <= bus.mem_rdata;
          r_addr  <= r_dst;
          r_state <= WRITE;
        end
        WRITE: begin
          r_result <= w_alu[DATA_W-1:0];
          r_carry  <= (r_op == OP_ADD || r_op == OP_SUB) && w_alu[DATA_W];
          r_zero   <= w_alu[DATA_W-1:0] == '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mem_sequencer.sv
// tb_alu_mem_sequencer: scoreboard bench with a 16-word memory model for alu_mem_sequencer
module tb_alu_mem_sequencer;
  localparam int DW = 8, AW = 4;
  typedef struct {
    int         cyc;
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, load = 1'b1;
  always #5 clk = ~clk;
  alu_mem_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  alu_mem_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0, n_err = 0, cyc = 0, busy_from = -1, busy_to = -2;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] m_res = 8'h00;
  logic m_c = 1'b0, m_z = 1'b0;
  exp_t sb[$];
  exp_t last;
  bit pend = 1'b0;
  function automatic logic [7:0] pre(input int i);
    case (i)
      1: return 8'h0F;
      2: return 8'h01;
      4: return 8'hFF;
      5: return 8'h01;
      9: return 8'hA5;
      default: return 8'(i * 17);
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 16; i++) mem[i] <= pre(i);
    else begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  always @(negedge clk) if (!rst && !load) begin
    chk("rd_wr_excl", {31'b0, bus.mem_rd_en & bus.mem_wr_en}, 0);
    if (cyc >= busy_from && cyc <= busy_to) chk("ready_busy", {31'b0, bus.cmd_ready}, 0);
    if (pend) begin
      pend = 1'b0;
      chk("result", {24'b0, bus.result}, {24'b0, last.res});
      chk("carry", {31'b0, bus.carry}, {31'b0, last.c});
      chk("zero", {31'b0, bus.zero}, {31'b0, last.z});
      chk("ready_after", {31'b0, bus.cmd_ready}, 1);
    end
    if (bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        last = sb.pop_front();
        chk("latency", cyc, last.cyc);
        chk("err", {31'b0, bus.err}, {31'b0, last.err});
        chk("wr_en", {31'b0, bus.mem_wr_en}, {31'b0, !last.err});
        chk("rd_en_done", {31'b0, bus.mem_rd_en}, 0);
        if (!last.err) begin
          chk("wr_addr", {28'b0, bus.mem_addr}, {28'b0, last.addr});
          chk("wr_data", {24'b0, bus.mem_wdata}, {24'b0, last.data});
        end
        pend = 1'b1;
      end
    end
  end
  // Caller must be just after a rising edge; returns just after the T1 edge (or later when holding).
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                      input bit hold, input bit push, output int acc);
    int w = 0, s;
    exp_t e;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_src_a = a;
    bus.cmd_src_b = b;
    bus.cmd_dst = d;
    while (!bus.cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    busy_from = acc + 1;
    busy_to = op > 3'd5 ? acc + 1 : acc + 4;
    if (push) begin
      e.err = op > 3'd5;
      e.cyc = e.err ? acc + 1 : acc + 4;
      e.addr = d;
      e.data = 8'h00;
      if (!e.err) begin
        case (op)
          3'd0: begin s = int'(ref_mem[a]) + int'(ref_mem[b]); e.data = 8'(s); m_c = s > 255; end
          3'd1: begin e.data = ref_mem[a] - ref_mem[b]; m_c = ref_mem[a] < ref_mem[b]; end
          3'd2: begin e.data = ref_mem[a] & ref_mem[b]; m_c = 1'b0; end
          3'd3: begin e.data = ref_mem[a] | ref_mem[b]; m_c = 1'b0; end
          3'd4: begin e.data = ref_mem[a] ^ ref_mem[b]; m_c = 1'b0; end
          default: begin e.data = ref_mem[a]; m_c = 1'b0; end
        endcase
        ref_mem[d] = e.data;
        m_res = e.data;
        m_z = e.data == 8'h00;
      end
      e.res = m_res;
      e.c = m_c;
      e.z = m_z;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (hold) repeat (3) begin @(posedge clk); #1; end
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    int a1, a2, t;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_dst = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pre(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.cmd_ready}, 1);
    chk("rst_rd", {31'b0, bus.mem_rd_en}, 0);
    chk("rst_wr", {31'b0, bus.mem_wr_en}, 0);
    chk("rst_addr", {28'b0, bus.mem_addr}, 0);
    chk("rst_wdata", {24'b0, bus.mem_wdata}, 0);
    chk("rst_done", {30'b0, bus.done, bus.err}, 0);
    chk("rst_flags", {22'b0, bus.result, bus.carry, bus.zero}, 0);
    load = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    send(3'd0, 4'd1, 4'd2, 4'd3, 0, 1, a1);
    send(3'd0, 4'd4, 4'd5, 4'd6, 0, 1, a1);
    send(3'd1, 4'd5, 4'd4, 4'd7, 0, 1, a1);
    send(3'd7, 4'd1, 4'd2, 4'd3, 0, 1, a1);
    send(3'd6, 4'd4, 4'd5, 4'd6, 0, 1, a1);
    repeat (2) begin @(posedge clk); #1; end
    send(3'd0, 4'd1, 4'd2, 4'd8, 0, 0, a1);
    @(posedge clk); #1;
    rst = 1'b1;
    busy_to = -2;
    @(posedge clk); #1;
    rst = 1'b0;
    t = cyc;
    m_res = 8'h00;
    m_c = 1'b0;
    m_z = 1'b0;
    chk("abort_ready", {31'b0, bus.cmd_ready}, 1);
    chk("abort_strobes", {30'b0, bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk("abort_addr", {28'b0, bus.mem_addr}, 0);
    chk("abort_done", {30'b0, bus.done, bus.err}, 0);
    chk("abort_flags", {22'b0, bus.result, bus.carry, bus.zero}, 0);
    send(3'd5, 4'd9, 4'd0, 4'd3, 0, 1, a1);
    chk("accept_after_rst", a1, t);
    send(3'd4, 4'd3, 4'd3, 4'd3, 1, 1, a1);
    send(3'd2, 4'd1, 4'd4, 4'd10, 0, 1, a1);
    send(3'd3, 4'd2, 4'd9, 4'd11, 0, 1, a2);
    chk("b2b_gap", a2 - a1, 5);
    for (int i = 0; i < 20 && (sb.size() != 0 || pend); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), {24'b0, mem[i]}, {24'b0, ref_mem[i]});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
